// File: rtl/clk_sel_pkg.sv
// rtl/clk_sel_pkg.sv - shared state encoding and default constants for the clock select controller
package clk_sel_pkg;

  typedef enum logic [1:0] {
    RUN0   = 2'd0,
    SW_TO1 = 2'd1,
    RUN1   = 2'd2,
    SW_TO0 = 2'd3
  } state_t;

  localparam int DEF_WINDOW    = 256;
  localparam int DEF_MIN_EDGES = 4;
  localparam int DEF_SETTLE    = 8;

endpackage

// File: rtl/clk_sel_ctrl_if.sv
// rtl/clk_sel_ctrl_if.sv - request/status bundle between a host and the clock select controller
interface clk_sel_ctrl_if;

  logic req_sel;
  logic fault_clr;
  logic sel;
  logic busy;
  logic active_src;
  logic clk0_ok;
  logic clk1_ok;
  logic fault;

  modport master (
    output req_sel, fault_clr,
    input  sel, busy, active_src, clk0_ok, clk1_ok, fault
  );

  modport slave (
    input  req_sel, fault_clr,
    output sel, busy, active_src, clk0_ok, clk1_ok, fault
  );

endinterface

// File: rtl/clk_activity_mon.sv
// rtl/clk_activity_mon.sv - toggle synchronizer, edge counter and per-window liveness flag for one source
module clk_activity_mon #(
  parameter int MIN_EDGES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tog,
  input  logic wrap,
  output logic ok
);

  localparam int CW = $clog2(MIN_EDGES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MIN_EDGES);

  logic          ff1, ff2, ff3;
  logic [CW-1:0] edge_cnt;
  logic [CW-1:0] cnt_nxt;
  logic          tog_edge;

  // The edge seen in the wrap cycle still counts toward the closing window.
  assign tog_edge = ff2 ^ ff3;
  assign cnt_nxt  = (tog_edge && (edge_cnt != CNT_MAX)) ? edge_cnt + 1'b1 : edge_cnt;

  // Two-flop synchronizer plus a history flop for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff1 <= 1'b0;
      ff2 <= 1'b0;
      ff3 <= 1'b0;
    end else begin
      ff1 <= tog;
      ff2 <= ff1;
      ff3 <= ff2;
    end
  end

  // Saturating edge count; at wrap the liveness verdict loads and the count restarts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt <= '0;
      ok       <= 1'b0;
    end else if (wrap) begin
      edge_cnt <= '0;
      ok       <= (cnt_nxt >= CNT_MAX);
    end else begin
      edge_cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/clk_sel_ctrl.sv
// rtl/clk_sel_ctrl.sv - clock source selection with liveness monitoring and failover to clk_in0
module clk_sel_ctrl
  import clk_sel_pkg::*;
#(
  parameter int WINDOW    = DEF_WINDOW,
  parameter int MIN_EDGES = DEF_MIN_EDGES,
  parameter int SETTLE    = DEF_SETTLE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tog0,
  input  logic tog1,
  clk_sel_ctrl_if.slave bus
);

  localparam int WW = $clog2(WINDOW);
  localparam logic [WW-1:0] WIN_LAST    = WW'(WINDOW - 1);
  localparam logic [7:0]    SETTLE_LAST = 8'(SETTLE - 1);

  state_t        state, state_nxt;
  logic [WW-1:0] win_cnt;
  logic          wrap;
  logic [7:0]    settle_cnt;
  logic          settle_done;
  logic          set_fault;
  logic          sel_nxt;
  logic          sel_q, active_q, fault_q;

  assign wrap        = (win_cnt == WIN_LAST);
  assign settle_done = (settle_cnt == SETTLE_LAST);

  // Free-running window counter shared by both monitors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) win_cnt <= '0;
    else        win_cnt <= win_cnt + 1'b1;
  end

  clk_activity_mon #(.MIN_EDGES(MIN_EDGES)) u_mon0 (
    .clk   (clk),
    .rst_n (rst_n),
    .tog   (tog0),
    .wrap  (wrap),
    .ok    (bus.clk0_ok)
  );

  clk_activity_mon #(.MIN_EDGES(MIN_EDGES)) u_mon1 (
    .clk   (clk),
    .rst_n (rst_n),
    .tog   (tog1),
    .wrap  (wrap),
    .ok    (bus.clk1_ok)
  );

  // Next-state selection; clk_in0 is the safe fallback and is never left on liveness grounds.
  always_comb begin
    state_nxt = state;
    set_fault = 1'b0;
    unique case (state)
      RUN0: begin
        if (bus.req_sel && bus.clk1_ok) state_nxt = SW_TO1;
      end
      SW_TO1: begin
        if (!bus.clk1_ok) begin
          state_nxt = SW_TO0;
          set_fault = 1'b1;
        end else if (settle_done) begin
          state_nxt = RUN1;
        end
      end
      RUN1: begin
        if (!bus.clk1_ok) begin
          state_nxt = SW_TO0;
          set_fault = 1'b1;
        end else if (!bus.req_sel) begin
          state_nxt = SW_TO0;
        end
      end
      SW_TO0: begin
        if (settle_done) state_nxt = RUN0;
      end
      default: state_nxt = RUN0;
    endcase
    sel_nxt = (state_nxt == SW_TO1) || (state_nxt == RUN1);
  end

  // State, registered select and delivered-source tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN0;
      sel_q    <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state <= state_nxt;
      sel_q <= sel_nxt;
      if ((state_nxt == RUN0) || (state_nxt == RUN1)) active_q <= sel_nxt;
    end
  end

  // Settle counter restarts on every state entry and stops at its terminal value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  settle_cnt <= '0;
    else if (state_nxt != state) settle_cnt <= '0;
    else if (!settle_done)       settle_cnt <= settle_cnt + 1'b1;
  end

  // Sticky fault: a new failover wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             fault_q <= 1'b0;
    else if (set_fault)     fault_q <= 1'b1;
    else if (bus.fault_clr) fault_q <= 1'b0;
  end

  assign bus.sel        = sel_q;
  assign bus.busy       = (state == SW_TO1) || (state == SW_TO0);
  assign bus.active_src = active_q;
  assign bus.fault      = fault_q;

endmodule
